// File: rtl/uart_msg_pkg.sv
// Shared definitions for the UART message link (TX serialiser and RX assembler).
// Messages are {payload[63:0], header[7:0]} and travel header byte first.
package uart_msg_pkg;

    localparam int UART_HEADER_BITS  = 8;
    localparam int UART_PAYLOAD_BITS = 64;
    localparam int UART_MSG_BITS     = UART_HEADER_BITS + UART_PAYLOAD_BITS;
    localparam int UART_MSG_BYTES    = UART_MSG_BITS / 8;

    typedef logic [UART_MSG_BITS-1:0] uart_msg_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } tx_state_e;

    // Plain-vector encodings of the sequencer states for state registers and debug ports.
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_LOAD = LOAD;
    localparam logic [1:0] ST_SEND = SEND;

endpackage

// File: rtl/uart_msg_tx_fifo.sv
// Synchronous FIFO with registered full/empty flags derived from a registered count.
// Pushes while full and pops while empty are ignored, so the count never over- or underflows.
module msg_fifo #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && !full_q;
        do_pop   = pop && !empty_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Storage is not reset: flushing the pointers and count is enough to discard it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/uart_msg_tx.sv
// Buffers whole 72-bit messages and serialises each as 9 bytes, header first, over valid/ready.
// Handshake: a byte moves on a clock edge where tx_valid && tx_ready; tx_valid/tx_data hold until then.
module uart_msg_tx
    import uart_msg_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MSG_BYTES  = UART_MSG_BYTES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            uart_out_req,
    input  uart_msg_t       uart_out_msg,
    output logic            uart_out_full,
    output logic            msg_dropped,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic            busy,
    output logic [1:0]      dbg_state
);

    localparam int CNT_W = $clog2(MSG_BYTES);

    logic [1:0]       state_q, state_d;
    uart_msg_t        shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tx_valid_q, tx_valid_d;
    logic             dropped_q, dropped_d;
    logic             busy_q, busy_d;
    logic             fifo_pop;
    logic             fifo_full, fifo_empty;
    uart_msg_t        fifo_rdata;

    msg_fifo #(
        .WIDTH (UART_MSG_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (uart_out_req),
        .wdata (uart_out_msg),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        tx_valid_d = tx_valid_q;
        fifo_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                fifo_pop   = 1'b1;
                shift_d    = fifo_rdata;
                cnt_d      = '0;
                tx_valid_d = 1'b1;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                // tx_valid_q is high for the whole of SEND, so tx_ready alone marks a handshake.
                if (tx_ready) begin
                    shift_d = shift_q >> 8;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(MSG_BYTES - 1)) begin
                        tx_valid_d = 1'b0;
                        // Skipping IDLE keeps the inter-frame gap to the single LOAD cycle.
                        state_d    = fifo_empty ? ST_IDLE : ST_LOAD;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
        dropped_d = uart_out_req && fifo_full;
        busy_d    = (uart_out_req && !fifo_full) || !fifo_empty || (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            dropped_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            tx_valid_q <= tx_valid_d;
            dropped_q  <= dropped_d;
            busy_q     <= busy_d;
        end
    end

    // The low byte of the shift register is the current byte; it is zero once a frame is fully shifted out.
    assign tx_data       = shift_q[7:0];
    assign tx_valid      = tx_valid_q;
    assign msg_dropped   = dropped_q;
    assign busy          = busy_q;
    assign uart_out_full = fifo_full;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_msg_tx.sv
// Bench for uart_msg_tx: directed frame table, overflow/back-to-back/reset sequences,
// and a randomized run checked against a byte-queue model of the message stream.
module tb_uart_msg_tx;
    import uart_msg_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_out_req;
    uart_msg_t  uart_out_msg;
    logic       uart_out_full;
    logic       msg_dropped;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic [1:0] dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0]  hdr;
        logic [63:0] pay;
        int          stall_idx;
        int          stall_len;
        logic [7:0]  bytes_exp [9];
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;

    uart_msg_tx #(.FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .uart_out_req  (uart_out_req),
        .uart_out_msg  (uart_out_msg),
        .uart_out_full (uart_out_full),
        .msg_dropped   (msg_dropped),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [7:0] byte_of(input uart_msg_t m, input int i);
        logic [71:0] t;
        t = m >> (8 * i);
        return t[7:0];
    endfunction

    task automatic model_push(input uart_msg_t m);
        for (int i = 0; i < UART_MSG_BYTES; i++) exp_q.push_back(byte_of(m, i));
    endtask

    task automatic wait_valid(input string name, input int budget);
        int c = 0;
        while (!tx_valid && c < budget) begin
            step();
            c++;
        end
        check({name, " wait_valid"}, tx_valid, 1'b1);
    endtask

    // Drains bytes with tx_ready=1, comparing each handshake against the model queue.
    task automatic collect(input string name, input int n, input int budget);
        int got = 0;
        int cyc = 0;
        tx_ready = 1'b1;
        while (got < n && cyc < budget) begin
            if (tx_valid) begin
                if (exp_q.size() == 0) check({name, " extra_byte"}, tx_data, 9'h100);
                else check({name, " byte"}, tx_data, exp_q.pop_front());
                got++;
            end
            step();
            cyc++;
        end
        check({name, " byte_count"}, got, n);
    endtask

    task automatic run_frame(input string name, input uart_msg_t msg, input int stall_idx,
                             input int stall_len, input logic [7:0] bytes_exp [9]);
        tx_ready     = 1'b1;
        uart_out_req = 1'b1;
        uart_out_msg = msg;
        step();
        uart_out_req = 1'b0;
        check({name, " busy@N"}, busy, 1'b1);
        check({name, " valid@N"}, tx_valid, 1'b0);
        step();
        check({name, " valid@N+1"}, tx_valid, 1'b0);
        step();
        for (int i = 0; i < 9; i++) begin
            check({name, " valid"}, tx_valid, 1'b1);
            check({name, " data"}, tx_data, bytes_exp[i]);
            if (i == stall_idx) begin
                tx_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    step();
                    check({name, " hold_valid"}, tx_valid, 1'b1);
                    check({name, " hold_data"}, tx_data, bytes_exp[i]);
                end
                tx_ready = 1'b1;
            end
            step();
        end
        check({name, " end_valid"}, tx_valid, 1'b0);
        check({name, " end_busy"}, busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        uart_msg_t m;
        uart_msg_t msgs [6];
        logic       prev_v, prev_r;
        logic [7:0] prev_d;
        int         gaps, nbytes;

        vecs[0] = '{hdr: 8'h01, pay: 64'h1122334455667788, stall_idx: -1, stall_len: 0,
                    bytes_exp: '{8'h01, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11}};
        vecs[1] = '{hdr: 8'h01, pay: 64'h1122334455667788, stall_idx: 3, stall_len: 5,
                    bytes_exp: '{8'h01, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11}};
        vecs[2] = '{hdr: 8'hA5, pay: 64'h0123456789ABCDEF, stall_idx: 0, stall_len: 3,
                    bytes_exp: '{8'hA5, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01}};
        vecs[3] = '{hdr: 8'h00, pay: 64'hFF00000000000080, stall_idx: 8, stall_len: 2,
                    bytes_exp: '{8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF}};

        // Reset and quiet period.
        reset        = 1'b1;
        uart_out_req = 1'b0;
        uart_out_msg = '0;
        tx_ready     = 1'b0;
        repeat (3) step();
        check("reset tx_valid", tx_valid, 1'b0);
        check("reset tx_data", tx_data, 8'h00);
        check("reset full", uart_out_full, 1'b0);
        check("reset dropped", msg_dropped, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset state", dbg_state, 2'd0);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            check("quiet outputs", {tx_valid, tx_data, uart_out_full, msg_dropped, busy}, 12'h000);
        end

        // Directed frames, with and without back-pressure.
        for (int v = 0; v < 4; v++) begin
            run_frame($sformatf("frame%0d", v), {vecs[v].pay, vecs[v].hdr},
                      vecs[v].stall_idx, vecs[v].stall_len, vecs[v].bytes_exp);
            step();
        end

        // Overflow: one frame in flight plus four queued fills the FIFO; a further push is dropped.
        tx_ready = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 6; k++) msgs[k] = {$urandom, $urandom, 8'(8'h10 + k)};
        uart_out_req = 1'b1;
        uart_out_msg = msgs[0];
        step();
        model_push(msgs[0]);
        uart_out_req = 1'b0;
        step();
        step();
        check("ovf in_flight_valid", tx_valid, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            uart_out_req = 1'b1;
            uart_out_msg = msgs[k];
            step();
            model_push(msgs[k]);
            check($sformatf("ovf full_after_push%0d", k), uart_out_full, (k == 4));
            check("ovf no_drop", msg_dropped, 1'b0);
        end
        uart_out_msg = msgs[5];
        step();
        uart_out_req = 1'b0;
        check("ovf dropped_pulse", msg_dropped, 1'b1);
        check("ovf still_full", uart_out_full, 1'b1);
        step();
        check("ovf dropped_clear", msg_dropped, 1'b0);
        check("ovf hold_header", tx_data, byte_of(msgs[0], 0));
        collect("ovf", 45, 200);
        check("ovf end_full", uart_out_full, 1'b0);
        check("ovf end_busy", busy, 1'b0);
        check("ovf queue_empty", exp_q.size(), 0);

        // Back-to-back: two queued frames separated by exactly one idle cycle.
        tx_ready = 1'b1;
        exp_q.delete();
        msgs[0]  = {$urandom, $urandom, 8'h5A};
        msgs[1]  = {$urandom, $urandom, 8'hC3};
        uart_out_req = 1'b1;
        uart_out_msg = msgs[0];
        step();
        uart_out_msg = msgs[1];
        step();
        uart_out_req = 1'b0;
        model_push(msgs[0]);
        model_push(msgs[1]);
        wait_valid("b2b", 10);
        gaps   = 0;
        nbytes = 0;
        for (int c = 0; c < 19; c++) begin
            if (tx_valid) begin
                check("b2b byte", tx_data, exp_q.pop_front());
                nbytes++;
            end else begin
                gaps++;
                check("b2b gap_position", c, 9);
            end
            step();
        end
        check("b2b gaps", gaps, 1);
        check("b2b bytes", nbytes, 18);
        check("b2b end_valid", tx_valid, 1'b0);
        check("b2b end_busy", busy, 1'b0);

        // Reset after the 4th byte handshake with two frames queued behind.
        step();
        tx_ready = 1'b1;
        for (int k = 0; k < 3; k++) msgs[k] = {$urandom, $urandom, 8'(8'h70 + k)};
        uart_out_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            uart_out_msg = msgs[k];
            step();
        end
        uart_out_req = 1'b0;
        wait_valid("rst", 10);
        repeat (4) step();
        check("rst fifth_byte", tx_data, byte_of(msgs[0], 4));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst valid", tx_valid, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst full", uart_out_full, 1'b0);
        check("rst data", tx_data, 8'h00);
        for (int c = 0; c < 5; c++) begin
            step();
            check("rst flushed", {tx_valid, busy}, 2'b00);
        end
        run_frame("post_rst", {vecs[2].pay, vecs[2].hdr}, -1, 0, vecs[2].bytes_exp);

        // Randomized traffic and back-pressure against the byte-queue model.
        exp_q.delete();
        tx_ready = 1'b0;
        prev_v   = 1'b0;
        prev_r   = 1'b0;
        prev_d   = 8'h00;
        for (int c = 0; c < 800; c++) begin
            if (prev_v && !prev_r) begin
                check("rnd hold_valid", tx_valid, 1'b1);
                check("rnd hold_data", tx_data, prev_d);
            end
            tx_ready = ($urandom_range(0, 3) != 0);
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) check("rnd extra_byte", tx_data, 9'h100);
                else check("rnd byte", tx_data, exp_q.pop_front());
            end
            if (!uart_out_full && $urandom_range(0, 9) == 0) begin
                m = {$urandom, $urandom, 8'($urandom)};
                uart_out_req = 1'b1;
                uart_out_msg = m;
                model_push(m);
            end else begin
                uart_out_req = 1'b0;
            end
            prev_v = tx_valid;
            prev_r = tx_ready;
            prev_d = tx_data;
            step();
        end
        uart_out_req = 1'b0;
        collect("rnd_drain", exp_q.size(), 1000);
        step();
        check("rnd end_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
